dp_ram_param: RTL
=================

# dp_ram_param

Parametrised true dual-port synchronous RAM: the next generation of the team's fixed 4-entry dual-port RAM. Two independent read/write ports share one clock. The block adds configurable data/address width and optional output pipelining. It defines cross-port collision behaviour and flags it, and it zero-fills the whole array after reset. It sits wherever two masters (for example, a producer and a consumer datapath) need shared scratch storage.

## Interface
Parameters:
- DATA_W, 8, data width of each word.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- READ_MODE, 0, cross-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 adds an output register stage, so read latency is 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  port A enable.
- wea  in  1  port A write (1) / read (0), qualified by ena.
- ada  in  ADDR_W  port A address.
- ina  in  DATA_W  port A write data.
- outa  out  DATA_W  port A read data.
- vala  out  1  port A read data valid, 1-cycle pulse per read.
- enb, web, adb, inb, outb, valb: port B equivalents of the above.
- busy  out  1  zero-fill in progress; all port requests are ignored.
- collision  out  1  1-cycle pulse: both ports accessed the same address in one cycle with at least one write.

## Operation
- Reset (rst_n=0, asynchronous):
  - outa=0, outb=0, vala=0, valb=0, collision=0, busy=1.
  - Fill counter cleared and pipeline registers cleared; memory contents undefined.
- State machine has two states, CLEAR and IDLE; reset forces CLEAR.
- CLEAR:
  - Each cycle, writes 0 to mem[cnt] and increments cnt.
  - After the cycle writing DEPTH-1, moves to IDLE; busy drops that same edge.
  - CLEAR lasts exactly DEPTH cycles after rst_n deasserts.
  - Port requests are discarded: no writes, no valids, no collision.
- IDLE, per port (X = a or b), on each clk edge:
  - enX=1, weX=1: mem[adX] <= inX. outX holds, valX=0.
  - enX=1, weX=0: mem[adX] is read and presented after the read latency, with valX=1.
  - enX=0: outX holds, valX=0.
- Cross-port, same address, same cycle (IDLE only):
  - Write/write: port A data is stored, port B's write is dropped, collision pulses.
  - Write on one port, read on the other: the reading port returns pre-write data if READ_MODE=0, or the written data if READ_MODE=1. collision pulses.
  - Read/read: both return the stored word, no collision.
- Different addresses: the ports are fully independent.
- Width rules:
  - Addresses are exactly ADDR_W bits, so there is no out-of-range case.
  - Data is stored and returned unmodified at DATA_W bits.
- Reset mid-operation (during CLEAR or IDLE):
  - Restarts CLEAR from address 0 and drops any in-flight read.
  - No valid is emitted for reads captured before the reset.

## Timing
- Read latency from the request edge:
  - OUT_REG=0: outX/valX update on the same edge the request is sampled, so data is visible from that edge until the next update.
  - OUT_REG=1: one edge later.
- Back-to-back reads on every cycle are supported. Throughput is 1 access per port per cycle.
- collision is registered and asserted for the cycle following the colliding request edge (OUT_REG=0), aligned with the read data. With OUT_REG=1 it is delayed one more cycle, still aligned with the data.
- Write-then-read, same address, consecutive cycles, either port pair: the read returns the new data.
- busy is 1 from reset assertion until DEPTH rising edges after rst_n deasserts.
- A request sampled on the edge where busy falls is ignored. The first accepted request is on the next edge.

## Test plan
- Reset then zero-fill (ADDR_W=4): release rst_n, then:
  - busy=1 for exactly 16 edges, then 0.
  - A request held during busy produces no vala and no write.
  - Afterwards, read A addr 5 -> outa=0x00, vala=1 for one cycle.
- Basic path, both OUT_REG values:
  - Write A addr 3 = 0xA5.
  - Next cycle, read B addr 3 -> outb=0xA5.
  - valb appears 1 cycle after the request (OUT_REG=0) or 2 cycles after (OUT_REG=1).
- Write/write collision:
  - Same cycle: A writes addr 7 = 0x11, B writes addr 7 = 0x22 -> collision pulses once.
  - A later read of addr 7 returns 0x11.
- Read-during-write, same cycle:
  - Setup: mem[9]=0x3C.
  - Same cycle: A writes addr 9 = 0xC3, B reads addr 9 -> collision pulses.
  - outb=0x3C with READ_MODE=0, outb=0xC3 with READ_MODE=1.
- Independent ports and hold:
  - A reads addr 1 while B writes addr 2 -> collision=0.
  - Then drop both enables -> outa/outb hold their last values, vala/valb=0.
- Reset mid-read:
  - Issue a read with OUT_REG=1 and assert rst_n=0 before its data appears.
  - Required: no valid pulse, outputs read 0, busy=1 again, and the full 16-cycle CLEAR repeats.

Source files
------------

// File: rtl/dp_ram_param.sv
// dp_ram_param: true dual-port RAM with post-reset zero-fill, cross-port collision flag and optional output register
module dp_ram_param #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int READ_MODE = 0,
   parameter int OUT_REG   = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              wea,
   input  logic [ADDR_W-1:0] ada,
   input  logic [DATA_W-1:0] ina,
   output logic [DATA_W-1:0] outa,
   output logic              vala,
   input  logic              enb,
   input  logic              web,
   input  logic [ADDR_W-1:0] adb,
   input  logic [DATA_W-1:0] inb,
   output logic [DATA_W-1:0] outb,
   output logic              valb,
   output logic              busy,
   output logic              collision
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [0:0] CLEAR = 1'b0;
   localparam logic [0:0] IDLE  = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] da_q, da_d, db_q, db_d;
   logic              va_q, va_d, vb_q, vb_d, col_q, col_d;
   logic              idle, same, wr_a, wr_b, rd_a, rd_b;

   assign idle = state_q == IDLE;
   assign same = ada == adb;
   assign wr_a = idle && ena && wea;
   assign wr_b = idle && enb && web;
   assign rd_a = idle && ena && !wea;
   assign rd_b = idle && enb && !web;
   assign busy = !idle;

   // fill sequencing plus first read stage; a cross-port write is forwarded in write-first mode
   always_comb begin
      state_d = (!idle && cnt_q == ADDR_W'(DEPTH - 1)) ? IDLE : state_q;
      cnt_d   = idle ? cnt_q : cnt_q + ADDR_W'(1);
      da_d    = rd_a ? ((READ_MODE != 0 && wr_b && same) ? inb : mem[ada]) : da_q;
      db_d    = rd_b ? ((READ_MODE != 0 && wr_a && same) ? ina : mem[adb]) : db_q;
      va_d    = rd_a;
      vb_d    = rd_b;
      col_d   = idle && ena && enb && same && (wea || web);
   end

   // control and first output stage; reset drops any in-flight read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         da_q    <= '0;
         db_q    <= '0;
         va_q    <= 1'b0;
         vb_q    <= 1'b0;
         col_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         da_q    <= da_d;
         db_q    <= db_d;
         va_q    <= va_d;
         vb_q    <= vb_d;
         col_q   <= col_d;
      end
   end

   // storage: zero-fill while clearing, otherwise port A wins a same-address write race
   always_ff @(posedge clk) begin
      if (!idle) begin
         mem[cnt_q] <= '0;
      end else begin
         if (wr_a) mem[ada] <= ina;
         if (wr_b && !(wr_a && same)) mem[adb] <= inb;
      end
   end

   if (OUT_REG != 0) begin : g_oreg
      logic [DATA_W-1:0] oa_q, ob_q;
      logic              ova_q, ovb_q, ocol_q;
      // extra output stage; the first stage already holds data between reads
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            oa_q   <= '0;
            ob_q   <= '0;
            ova_q  <= 1'b0;
            ovb_q  <= 1'b0;
            ocol_q <= 1'b0;
         end else begin
            oa_q   <= da_q;
            ob_q   <= db_q;
            ova_q  <= va_q;
            ovb_q  <= vb_q;
            ocol_q <= col_q;
         end
      end
      assign outa      = oa_q;
      assign outb      = ob_q;
      assign vala      = ova_q;
      assign valb      = ovb_q;
      assign collision = ocol_q;
   end else begin : g_direct
      assign outa      = da_q;
      assign outb      = db_q;
      assign vala      = va_q;
      assign valb      = vb_q;
      assign collision = col_q;
   end
endmodule
